// File: rtl/dmem_sram_bridge_if.sv
// Bus bundle between the MEM-stage data port, the SRAM bridge and the external SRAM.
// The bridge takes the slave view; the MEM stage / SRAM side takes the master view.
interface dmem_sram_bridge_if #(
    parameter int ADDR_W = 20
);
    logic [31:0]       dm_addr_i;
    logic [3:0]        dm_wbe_n_i;
    logic [31:0]       dm_wdata_i;
    logic              dm_re_i;
    logic              dm_we_i;
    logic [31:0]       dm_rdata_o;
    logic              dm_stall_o;
    logic              dm_misalign_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i;
    logic              sram_data_oe_o;
    logic [3:0]        sram_be_n_o;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic              sram_we_n_o;

    modport master (
        output dm_addr_i, dm_wbe_n_i, dm_wdata_i, dm_re_i, dm_we_i, sram_rdata_i,
        input  dm_rdata_o, dm_stall_o, dm_misalign_o, sram_addr_o, sram_wdata_o,
        input  sram_data_oe_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o
    );

    modport slave (
        input  dm_addr_i, dm_wbe_n_i, dm_wdata_i, dm_re_i, dm_we_i, sram_rdata_i,
        output dm_rdata_o, dm_stall_o, dm_misalign_o, sram_addr_o, sram_wdata_o,
        output sram_data_oe_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o
    );
endinterface

// File: rtl/dmem_sram_bridge.sv
// Data-memory responder: one load/store at a time to an async 32-bit SRAM, with
// byte-lane alignment, programmable strobe wait states and a pipeline stall.
module dmem_sram_bridge #(
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_sram_bridge_if.slave    bus,
    output logic [2:0]           dbg_state_o
);
    // Handshake: a valid aligned request seen in IDLE is accepted that cycle and
    // dm_stall_o stays high until the access completes; MEM holds dm_* inputs
    // stable while dm_stall_o is high and may present the next request once it drops.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_WREC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              data_oe_q, data_oe_d;

    logic [1:0]        off;
    logic [3:0]        lane_en;
    logic [3:0]        lane_rot;
    logic              req_valid;
    logic              misalign;
    logic              idle;
    logic              accept;
    logic              unused_addr_hi;

    always_comb begin
        off       = bus.dm_addr_i[1:0];
        lane_en   = ~bus.dm_wbe_n_i;
        req_valid = (bus.dm_re_i | bus.dm_we_i) && (bus.dm_wbe_n_i != 4'b1111);
        misalign  = req_valid &&
                    (((bus.dm_wbe_n_i == 4'b1100) && off[0]) ||
                     ((bus.dm_wbe_n_i == 4'b0000) && (off != 2'b00)));
        idle      = (state_q == S_IDLE);
        accept    = idle && req_valid && !misalign;
        case (off)
            2'd0:    lane_rot = lane_en;
            2'd1:    lane_rot = {lane_en[2:0], lane_en[3]};
            2'd2:    lane_rot = {lane_en[1:0], lane_en[3:2]};
            default: lane_rot = {lane_en[0], lane_en[3:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_n_d    = be_n_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        data_oe_d = data_oe_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.dm_addr_i[ADDR_W+1:2];
                    be_n_d  = ~lane_rot;
                    wdata_d = bus.dm_wdata_i << {off, 3'b000};
                    off_d   = off;
                    cnt_d   = WAIT_INIT;
                    ce_n_d  = 1'b0;
                    if (bus.dm_we_i) begin
                        state_d   = S_WRITE;
                        we_n_d    = 1'b0;
                        data_oe_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == 3'd0) begin
                    // Last strobe cycle: SRAM data has settled, capture it right-aligned.
                    rdata_d = bus.sram_rdata_i >> {off_q, 3'b000};
                    state_d = S_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 4'b1111;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_WREC;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WREC: begin
                // we_n already released; chip enable, address and data kept for hold time.
                state_d   = S_DONE;
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                be_n_d    = 4'b1111;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            off_q     <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            be_n_q    <= 4'b1111;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            be_n_q    <= be_n_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign unused_addr_hi     = ^bus.dm_addr_i[31:ADDR_W+2];

    assign bus.dm_stall_o     = accept || (state_q == S_READ) ||
                                (state_q == S_WRITE) || (state_q == S_WREC);
    assign bus.dm_misalign_o  = idle && misalign;
    assign bus.dm_rdata_o     = rdata_q;
    assign bus.sram_addr_o    = addr_q;
    assign bus.sram_wdata_o   = wdata_q;
    assign bus.sram_be_n_o    = be_n_q;
    assign bus.sram_ce_n_o    = ce_n_q;
    assign bus.sram_oe_n_o    = oe_n_q;
    assign bus.sram_we_n_o    = we_n_q;
    assign bus.sram_data_oe_o = data_oe_q;
    assign dbg_state_o        = state_q;
endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Data-side memory responder sitting between the MEM stage's `dm_*` data-memory port and an external asynchronous 32-bit SRAM. Accepts one load or store at a time and applies byte-lane alignment from `addr[1:0]`. Sequences the SRAM strobes with configurable wait states and stalls the pipeline until the access completes. Returns load data right-aligned, so MEM's sign/zero extension works on `dm_rdata[7:0]` / `[15:0]` directly.

## Interface

Parameters:
- `ADDR_W`, 20, SRAM word-address width; SRAM word address = `dm_addr_i[ADDR_W+1:2]`.
- `WAIT_CYC`, 1, extra strobe cycles per access; legal range 0..7.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dm_addr_i`  in  32  byte address from MEM.
- `dm_wbe_n_i`  in  4  active-low size mask: 1110 byte, 1100 half, 0000 word, 1111 no access.
- `dm_wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `dm_re_i`  in  1  load request.
- `dm_we_i`  in  1  store request; wins if both asserted.
- `dm_rdata_o`  out  32  registered load data, right-aligned.
- `dm_stall_o`  out  1  high while request is pending or in flight; MEM holds all `dm_*` inputs while high.
- `dm_misalign_o`  out  1  combinational flag for a rejected misaligned request.
- `sram_addr_o`  out  ADDR_W  word address.
- `sram_wdata_o`  out  32  lane-shifted write data.
- `sram_rdata_i`  in  32  SRAM read data.
- `sram_data_oe_o`  out  1  drive enable for the board-level tristate.
- `sram_be_n_o`  out  4  active-low lane enables.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o`  out  1 each  active-low strobes.

## Operation

- `off = dm_addr_i[1:0]`. Request is valid when `(dm_re_i | dm_we_i) && dm_wbe_n_i != 4'b1111`.
- Misaligned requests:
  - half with `off[0]=1`, or word with `off!=0`.
  - `dm_misalign_o=1` in that cycle.
  - No SRAM access, `dm_stall_o=0`, `dm_rdata_o` unchanged, FSM stays IDLE.
- Write alignment:
  - lane enable = `~dm_wbe_n_i` rotated left by `off`; `sram_be_n_o` is its inverse.
  - `sram_wdata_o = dm_wdata_i << (8*off)`.
- Read alignment: `dm_rdata_o = sram_rdata_i >> (8*off)`, captured at the last strobe cycle. Upper bytes are don't-care to MEM but are still shifted, not masked.
- FSM states: IDLE, READ, WRITE, WREC, DONE; wait counter is 3 bits.
  - IDLE, valid aligned request: register addr, be_n, wdata and off; counter=`WAIT_CYC`; go to WRITE if `dm_we_i`, else READ.
  - READ: `ce_n=oe_n=0`. Counter decrements each cycle. When counter==0, capture aligned data into `dm_rdata_o` and go to DONE.
  - WRITE: `ce_n=we_n=0`, `data_oe=1`. Counter decrements each cycle. When counter==0, go to WREC.
  - WREC: `we_n=1`, `ce_n=0`, `data_oe=1`, addr and data held (hold time); go to DONE.
  - DONE: all strobes high, `data_oe=0`, `dm_stall_o=0`; go to IDLE unconditionally.
- `dm_stall_o = (IDLE & valid aligned request) | READ | WRITE | WREC`. Registered outputs plus combinational stall.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE.

## Timing

- Reset values:
  - state IDLE, counter 0.
  - `sram_ce_n_o/oe_n_o/we_n_o=1`, `sram_be_n_o=4'b1111`, `sram_data_oe_o=0`.
  - `sram_addr_o=0`, `sram_wdata_o=0`, `dm_rdata_o=0`.
  - `dm_stall_o` and `dm_misalign_o` are 0 unless driven by inputs in IDLE.
- SRAM outputs change only on clock edges. Strobes first assert in the cycle after acceptance.
- Load: `WAIT_CYC+3` cycles, counted as accept + `(WAIT_CYC+1)` READ + DONE.
  - `dm_stall_o` high for `WAIT_CYC+2` cycles.
  - `dm_rdata_o` is valid from the DONE cycle and held until the next load capture.
- Store: `WAIT_CYC+4` cycles, counted as accept + `(WAIT_CYC+1)` WRITE + WREC + DONE.
  - `dm_stall_o` high for `WAIT_CYC+3` cycles.
- Reset mid-access (READ/WRITE/WREC): on the next edge all strobes go high, `data_oe=0` and state returns to IDLE. No partial `dm_rdata_o` capture occurs.
- Inputs changing while stalled are a protocol violation. The block uses its registered copies only.

## Test plan

- Reset, then idle with no request: strobes 1, `be_n=1111`, `data_oe=0`, `dm_rdata_o=0`, `dm_stall_o=0`.
- Word store, `WAIT_CYC=1`, addr 0x10, wdata 0xDEADBEEF:
  - `sram_addr=4`, `be_n=0000`.
  - `we_n` low exactly 2 cycles, then 1 WREC cycle with data still driven.
  - Stall high 4 cycles, total 5.
- Byte store, addr 0x13, `wbe_n=1110`, wdata 0x000000A5: `sram_be_n=0111`, `sram_wdata=0xA5000000`, `sram_addr=4`.
- Half load, addr 0x12, `wbe_n=1100`, `sram_rdata=0x12345678`, `WAIT_CYC=0`: stall 2 cycles; `dm_rdata_o[15:0]=0x1234` in the DONE cycle.
- Misaligned word load at addr 0x05: `dm_misalign_o=1` for that cycle, no strobe activity, stall 0, `dm_rdata_o` unchanged.
- `rst` asserted during the second WRITE cycle: next cycle `we_n=ce_n=1`, `data_oe=0`, state IDLE. A following load then completes normally.
